// File: rtl/shape_calc_engine.sv
// Shape calculation stage: perimeter/area/predicates for RECTANGLE and TRIANGLE with a valid/ready response.
// Optional macro SHAPE_CALC_FAST_MUL_EN replaces the W-cycle shift-add multiplier with a combinational one.
module shape_calc_engine #(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       shape,
    input  logic [5:0]       operation,
    input  logic [W-1:0]     side_a,
    input  logic [W-1:0]     side_b,
    input  logic [W-1:0]     side_c,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [2*W-1:0]   result,
    output logic             result_err
);
    localparam int unsigned RW = 2 * W;
    localparam logic [1:0] ShapeRect = 2'b01;
    localparam logic [1:0] ShapeTri  = 2'b10;
    localparam logic [5:0] OpPerim   = 6'h00;
    localparam logic [5:0] OpArea    = 6'h01;
    localparam logic [5:0] OpIsSq    = 6'h10;
    localparam logic [5:0] OpIsEq    = 6'h20;
    localparam logic [5:0] OpIsIso   = 6'h21;

    typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

    state_e          state_q;
    logic            busy_q;
    logic            valid_q;
    logic            err_q;
    logic [RW-1:0]   result_q;

    logic [RW-1:0]   a_ext, b_ext, c_ext;
    logic            ab_eq, bc_eq, ac_eq;
    logic            legal;
    logic [RW-1:0]   calc;

    assign a_ext = RW'(side_a);
    assign b_ext = RW'(side_b);
    assign c_ext = RW'(side_c);
    assign ab_eq = (side_a == side_b);
    assign bc_eq = (side_b == side_c);
    assign ac_eq = (side_a == side_c);

`ifdef SHAPE_CALC_FAST_MUL_EN
    logic [RW-1:0] prod;
    assign prod = a_ext * b_ext;
`else
    localparam int unsigned CntW = $clog2(W) + 1;
    logic            go_mul;
    logic [RW-1:0]   mcand_q;
    logic [W-1:0]    mplier_q;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   acc_nxt;
    logic [CntW-1:0] cnt_q;
    logic            tri_q;

    assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif

    // Decode legality and the single-cycle result straight from the request inputs.
    always_comb begin
        legal = 1'b0;
        calc  = '0;
`ifndef SHAPE_CALC_FAST_MUL_EN
        go_mul = 1'b0;
`endif
        if (shape == ShapeRect || shape == ShapeTri) begin
            case (operation)
                OpPerim: begin
                    legal = 1'b1;
                    calc  = (shape == ShapeRect) ? (a_ext + b_ext) << 1 : a_ext + b_ext + c_ext;
                end
                OpArea: begin
                    legal = 1'b1;
`ifdef SHAPE_CALC_FAST_MUL_EN
                    calc  = (shape == ShapeTri) ? prod >> 1 : prod;
`else
                    go_mul = 1'b1;
`endif
                end
                OpIsSq: begin
                    if (shape == ShapeRect) begin
                        legal   = 1'b1;
                        calc[0] = ab_eq;
                    end
                end
                OpIsEq: begin
                    if (shape == ShapeTri) begin
                        legal   = 1'b1;
                        calc[0] = ab_eq && bc_eq;
                    end
                end
                OpIsIso: begin
                    if (shape == ShapeTri) begin
                        legal   = 1'b1;
                        calc[0] = ab_eq || bc_eq || ac_eq;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
`ifndef SHAPE_CALC_FAST_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tri_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q <= 1'b1;
`ifdef SHAPE_CALC_FAST_MUL_EN
                        state_q  <= StResp;
                        valid_q  <= 1'b1;
                        result_q <= legal ? calc : '0;
                        err_q    <= !legal;
`else
                        if (go_mul) begin
                            state_q  <= StMul;
                            mcand_q  <= a_ext;
                            mplier_q <= side_b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            tri_q    <= (shape == ShapeTri);
                        end else begin
                            state_q  <= StResp;
                            valid_q  <= 1'b1;
                            result_q <= legal ? calc : '0;
                            err_q    <= !legal;
                        end
`endif
                    end
                end
`ifndef SHAPE_CALC_FAST_MUL_EN
                StMul: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    // Last iteration: publish the product including this cycle's partial sum.
                    if (cnt_q == CntW'(W - 1)) begin
                        state_q  <= StResp;
                        valid_q  <= 1'b1;
                        result_q <= tri_q ? acc_nxt >> 1 : acc_nxt;
                        err_q    <= 1'b0;
                    end
                end
`endif
                StResp: begin
                    if (result_ready) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b0;
                        err_q    <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign result_err   = err_q;

endmodule

// File: tb/tb_shape_calc_engine.sv
// Self-checking bench for shape_calc_engine: vector table plus backpressure, dropped-start and reset sequences.
module tb_shape_calc_engine;
    localparam int W = 16;
`ifdef SHAPE_CALC_FAST_MUL_EN
    localparam int AreaLat = 1;
`else
    localparam int AreaLat = 1 + W;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      shape;
    logic [5:0]      operation;
    logic [W-1:0]    side_a, side_b, side_c;
    logic            busy;
    logic            result_valid;
    logic            result_ready;
    logic [2*W-1:0]  result;
    logic            result_err;

    shape_calc_engine #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .shape        (shape),
        .operation    (operation),
        .side_a       (side_a),
        .side_b       (side_b),
        .side_c       (side_c),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_err   (result_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     shape;
        logic [5:0]     op;
        logic [W-1:0]   a, b, c;
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    // Drive one request for the acceptance edge, record its expectation, then scramble the inputs.
    task automatic issue(input logic [1:0] s, input logic [5:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [2*W-1:0] res, input logic err);
        start     = 1'b1;
        shape     = s;
        operation = op;
        side_a    = a;
        side_b    = b;
        side_c    = c;
        sb.push_back('{res: res, err: err});
        tick();
        start     = 1'b0;
        shape     = 2'($urandom);
        operation = 6'($urandom);
        side_a    = 16'($urandom);
        side_b    = 16'($urandom);
        side_c    = 16'($urandom);
    endtask

    task automatic await_resp(input string name, input int exp_lat);
        int   lat = 1;
        exp_t e;
        chk({name, "_busy"}, busy, 1);
        while (!result_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        if (result_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_res"}, result, e.res);
            chk({name, "_err"}, result_err, e.err);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_resp: got no response, expected one", name);
        end
    endtask

    task automatic handshake(input string name);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({name, "_hs_valid"}, result_valid, 0);
        chk({name, "_hs_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int resp_cnt;
        vecs[0]  = '{2'b01, 6'h00, 16'd3,      16'd5,      16'd0, 32'd16,         1'b0, 1};
        vecs[1]  = '{2'b10, 6'h00, 16'd3,      16'd4,      16'd5, 32'd12,         1'b0, 1};
        vecs[2]  = '{2'b01, 6'h01, 16'hFFFF,   16'hFFFF,   16'd0, 32'hFFFE0001,   1'b0, AreaLat};
        vecs[3]  = '{2'b10, 6'h01, 16'd5,      16'd3,      16'd9, 32'd7,          1'b0, AreaLat};
        vecs[4]  = '{2'b10, 6'h21, 16'd4,      16'd7,      16'd4, 32'd1,          1'b0, 1};
        vecs[5]  = '{2'b10, 6'h20, 16'd4,      16'd7,      16'd4, 32'd0,          1'b0, 1};
        vecs[6]  = '{2'b01, 6'h10, 16'd9,      16'd9,      16'd0, 32'd1,          1'b0, 1};
        vecs[7]  = '{2'b01, 6'h10, 16'd9,      16'd8,      16'd0, 32'd0,          1'b0, 1};
        vecs[8]  = '{2'b10, 6'h10, 16'd9,      16'd9,      16'd9, 32'd0,          1'b1, 1};
        vecs[9]  = '{2'b00, 6'h00, 16'd3,      16'd5,      16'd0, 32'd0,          1'b1, 1};
        vecs[10] = '{2'b01, 6'h3F, 16'd3,      16'd5,      16'd0, 32'd0,          1'b1, 1};
        vecs[11] = '{2'b10, 6'h20, 16'd6,      16'd6,      16'd6, 32'd1,          1'b0, 1};
        vecs[12] = '{2'b01, 6'h01, 16'd200,    16'd300,    16'd0, 32'd60000,      1'b0, AreaLat};
        vecs[13] = '{2'b10, 6'h01, 16'd7,      16'd7,      16'd0, 32'd24,         1'b0, AreaLat};
        vecs[14] = '{2'b01, 6'h00, 16'hFFFF,   16'hFFFF,   16'd0, 32'h0003FFFC,   1'b0, 1};
        vecs[15] = '{2'b11, 6'h01, 16'd7,      16'd7,      16'd0, 32'd0,          1'b1, 1};
        vecs[16] = '{2'b10, 6'h21, 16'd1,      16'd2,      16'd3, 32'd0,          1'b0, 1};
        vecs[17] = '{2'b10, 6'h01, 16'hFFFF,   16'hFFFF,   16'd0, 32'h7FFF0000,   1'b0, AreaLat};

        rst = 1'b1; start = 1'b0; result_ready = 1'b0;
        shape = '0; operation = '0; side_a = '0; side_b = '0; side_c = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_err", result_err, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            wait_idle();
            issue(vecs[i].shape, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
                  vecs[i].res, vecs[i].err);
            await_resp($sformatf("vec%0d", i), vecs[i].lat);
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: response must hold steady while the consumer stalls.
        wait_idle();
        issue(2'b01, 6'h00, 16'd10, 16'd20, 16'd0, 32'd60, 1'b0);
        await_resp("bp", 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i), result_valid, 1);
            chk($sformatf("bp_result%0d", i), result, 32'd60);
        end
        handshake("bp");

        // Starts while busy and on the handshake edge are dropped.
        wait_idle();
        issue(2'b01, 6'h01, 16'd3, 16'd4, 16'd0, 32'd12, 1'b0);
        start = 1'b1; shape = 2'b01; operation = 6'h00; side_a = 16'd1; side_b = 16'd1;
        tick();
        start = 1'b0;
        await_resp("drop", AreaLat - 1);
        start = 1'b1; shape = 2'b01; operation = 6'h00; side_a = 16'd2; side_b = 16'd2;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        chk("drop_hs_valid", result_valid, 0);
        chk("drop_hs_busy", busy, 0);
        resp_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (result_valid || busy) resp_cnt++;
        end
        chk("drop_extra_resp", resp_cnt, 0);

        // Reset in the middle of a request discards it.
        issue(2'b01, 6'h01, 16'd100, 16'd200, 16'd0, 32'd20000, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_err", result_err, 0);
        issue(2'b01, 6'h00, 16'd7, 16'd8, 16'd0, 32'd30, 1'b0);
        await_resp("post_rst", 1);
        handshake("post_rst");

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shape_calc_engine.md
# shape_calc_engine

Computation stage downstream of the shape processor's CTRL SFR. It consumes the committed SHAPE/OPERATION pair and three side-length operands, then produces one result per request through a valid/ready response interface. It covers every operation defined for RECTANGLE and TRIANGLE and flags illegal shape/operation combinations as errors. Area uses an iterative shift-add multiplier unless the fast-multiply option is compiled in.

## Interface
- W, 16, operand width in bits; legal range 4..32; result width is 2W
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; accepted when start && !busy
- shape  in  2  RECTANGLE=2'b01, TRIANGLE=2'b10; all other values are illegal
- operation  in  6  PERIMETER=6'h00, AREA=6'h01, IS_SQUARE=6'h10, IS_EQUILATERAL=6'h20, IS_ISOSCELES=6'h21
- side_a, side_b, side_c  in  W each  unsigned operands; side_c is used only by TRIANGLE PERIMETER and the TRIANGLE predicates
- busy  out  1  high in every state other than IDLE
- result_valid  out  1  response available
- result_ready  in  1  consumer accepts the response
- result  out  2W  computed value; zero-extended
- result_err  out  1  illegal combination; `result` is 0 when set

## Operation
- States are IDLE, MUL and RESP.
- On acceptance, the block captures shape, operation and all three sides. Later input changes have no effect.
- Legality:
  - PERIMETER and AREA are legal for both shapes.
  - IS_SQUARE is legal only for RECTANGLE.
  - IS_EQUILATERAL and IS_ISOSCELES are legal only for TRIANGLE.
  - Any other shape or operation code is illegal. The response is result_err=1, result=0, and it uses the IDLE→RESP path.
- Results:
  - RECT PERIMETER: 2*(a+b).
  - RECT AREA: a*b.
  - RECT IS_SQUARE: (a==b).
  - TRI PERIMETER: a+b+c.
  - TRI AREA: floor(a*b/2), with a as base and b as height.
  - TRI IS_EQUILATERAL: (a==b && b==c).
  - TRI IS_ISOSCELES: (a==b || b==c || a==c).
- Predicate results are 1 or 0 in bit 0; upper bits are 0.
- All arithmetic is done at 2W width. No overflow is possible for W ≥ 4.
- Transitions:
  - IDLE → MUL when the accepted request is a legal AREA and the slow multiplier is in use.
  - IDLE → RESP for every other accepted request.
  - MUL → RESP after exactly W iterations. Each iteration is LSB-first shift-add on captured b.
  - RESP → IDLE on result_valid && result_ready.
- result_valid equals (state==RESP). While RESP holds, result and result_err stay stable.
- A start that coincides with the RESP handshake is ignored, because busy is still high. A start while busy is always dropped; there is no queue.

## Timing
- Reset values: state=IDLE, busy=0, result_valid=0, result=0, result_err=0. Multiplier accumulator and counter are cleared.
- Reset in MUL or RESP aborts the request. Outputs take reset values in the cycle after rst is sampled high. The pending response is lost.
- Let k be the acceptance edge.
  - Non-AREA and error requests: result_valid=1 from cycle k+1.
  - AREA with the slow multiplier: result_valid=1 from cycle k+1+W (W=16 gives k+17).
- busy rises in cycle k+1. It falls in the cycle after the handshake edge.
- The earliest next acceptance is one cycle after the handshake edge. Peak throughput is one request per 2 cycles for non-AREA requests.
- result_ready is a don't-care outside RESP.

## Configuration
- SHAPE_CALC_FAST_MUL_EN
  - Defined: the multiply is combinational at 2W width and the MUL state is not built. AREA follows IDLE→RESP with result_valid at k+1.
  - Undefined: the W-cycle shift-add multiplier is used, with a counter of clog2(W)+1 bits. Latency is k+1+W.
- Result values are identical with and without the macro.

## Test plan
- RECT PERIMETER, a=3, b=5 → result=16, err=0, valid at k+1. TRI PERIMETER, a=3, b=4, c=5 → result=12.
- RECT AREA, a=b=16'hFFFF → result=32'hFFFE0001, valid at k+17 (k+1 with SHAPE_CALC_FAST_MUL_EN). TRI AREA, a=5, b=3 → result=7.
- TRI, a=4, b=7, c=4: IS_ISOSCELES → 1, IS_EQUILATERAL → 0. RECT IS_SQUARE, a=b=9 → 1; a=9, b=8 → 0.
- Illegal combinations (shape=TRIANGLE with IS_SQUARE; shape=2'b00 with PERIMETER; shape=RECT with op=6'h3F) → result_err=1, result=0, valid at k+1.
- Backpressure: hold result_ready=0 for 5 cycles in RESP → result stable throughout. Pulse start during MUL and during the handshake cycle → both dropped, exactly one response.
- Assert rst at cycle k+5 of a slow AREA request → next cycle busy=0, valid=0, result=0. A fresh RECT PERIMETER request then completes normally.
